// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg
// Shared definitions for the traffic light controller and its safety monitor:
// one-hot light encodings, the monitor's fault codes and a helper that checks
// a light value for a legal encoding.
package traffic_light_pkg;

  typedef logic [2:0] light_t;

  localparam light_t LIGHT_RED    = 3'b100;
  localparam light_t LIGHT_YELLOW = 3'b010;
  localparam light_t LIGHT_GREEN  = 3'b001;

  // Lower value = higher priority when several faults coincide
  localparam logic [2:0] FLT_NONE         = 3'd0;
  localparam logic [2:0] FLT_CONFLICT     = 3'd1;
  localparam logic [2:0] FLT_INVALID      = 3'd2;
  localparam logic [2:0] FLT_ILLEGAL      = 3'd3;
  localparam logic [2:0] FLT_SHORT_GREEN  = 3'd4;
  localparam logic [2:0] FLT_SHORT_YELLOW = 3'd5;
  localparam logic [2:0] FLT_WATCHDOG     = 3'd6;

  function automatic logic light_is_valid(input light_t light);
    return (light == LIGHT_RED) || (light == LIGHT_YELLOW) || (light == LIGHT_GREEN);
  endfunction

endpackage

// File: rtl/light_phase_checker.sv
// light_phase_checker
// Per-direction phase checker. Tracks how many samples the current light value
// has been held and judges the cur/prev pair of one direction.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_cur, i_prev    current and previous registered light samples
//   o_valid          i_cur is a legal one-hot encoding
//   o_illegal        change other than R->G, G->Y, Y->R (both samples valid)
//   o_short_green    G->Y taken before MIN_GREEN samples of green
//   o_short_yellow   Y->R taken before MIN_YELLOW samples of yellow
module light_phase_checker
  import traffic_light_pkg::*;
#(
  parameter int                CNT_W      = 16,
  parameter logic [CNT_W-1:0]  MIN_GREEN  = 16'd1000,
  parameter logic [CNT_W-1:0]  MIN_YELLOW = 16'd100
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  light_t i_cur,
  input  light_t i_prev,
  output logic   o_valid,
  output logic   o_illegal,
  output logic   o_short_green,
  output logic   o_short_yellow
);

  localparam logic [CNT_W-1:0] DWELL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_dwell;
  logic             w_both_valid;
  logic             w_changed;
  logic             w_r2g;
  logic             w_g2y;
  logic             w_y2r;

  // Dwell counter: samples the value in prev has been held when the change
  // reaches cur, so the count seen at a transition is the old phase length.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dwell <= DWELL_ONE;
    end else if (i_cur != i_prev) begin
      r_dwell <= DWELL_ONE;
    end else if (r_dwell != {CNT_W{1'b1}}) begin
      r_dwell <= r_dwell + DWELL_ONE;
    end else begin
      r_dwell <= r_dwell;
    end
  end

  // Transition legality and minimum-phase checks
  always_comb begin
    w_both_valid = light_is_valid(i_cur) && light_is_valid(i_prev);
    w_changed    = (i_cur != i_prev);
    w_r2g        = (i_prev == LIGHT_RED)    && (i_cur == LIGHT_GREEN);
    w_g2y        = (i_prev == LIGHT_GREEN)  && (i_cur == LIGHT_YELLOW);
    w_y2r        = (i_prev == LIGHT_YELLOW) && (i_cur == LIGHT_RED);

    o_valid        = light_is_valid(i_cur);
    o_illegal      = w_both_valid && w_changed && !(w_r2g || w_g2y || w_y2r);
    o_short_green  = w_both_valid && w_g2y && (r_dwell < MIN_GREEN);
    o_short_yellow = w_both_valid && w_y2r && (r_dwell < MIN_YELLOW);
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Independent safety monitor for the traffic light controller outputs.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr_fault       clears the latched fault (a fault detected the same cycle wins)
//   ns_light        observed NS light (100 red, 010 yellow, 001 green)
//   ew_light        observed EW light, same encoding
//   fault           sticky fault flag
//   fault_code      code of the first fault since the last clear
//   conflict        per-cycle flag: both directions non-red
//   cycle_count     NS red-to-green transitions, wrapping
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int                CNT_W      = 16,
  parameter logic [CNT_W-1:0]  MIN_GREEN  = 16'd1000,
  parameter logic [CNT_W-1:0]  MIN_YELLOW = 16'd100,
  parameter logic [CNT_W-1:0]  MAX_STABLE = 16'd60000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_fault,
  input  logic [2:0] ns_light,
  input  logic [2:0] ew_light,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       conflict,
  output logic [7:0] cycle_count
);

  light_t           r_cur_ns;
  light_t           r_prev_ns;
  light_t           r_cur_ew;
  light_t           r_prev_ew;
  logic [CNT_W-1:0] r_wdog;
  logic             r_fault;
  logic [2:0]       r_fault_code;
  logic             r_conflict;
  logic [7:0]       r_cycle_count;

  logic       w_ns_valid, w_ns_illegal, w_ns_short_g, w_ns_short_y;
  logic       w_ew_valid, w_ew_illegal, w_ew_short_g, w_ew_short_y;
  logic       w_conflict;
  logic       w_ns_r2g;
  logic [2:0] w_code;

  light_phase_checker #(
    .CNT_W(CNT_W), .MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW)
  ) u_ns_chk (
    .i_clk(clk), .i_rst(rst), .i_cur(r_cur_ns), .i_prev(r_prev_ns),
    .o_valid(w_ns_valid), .o_illegal(w_ns_illegal),
    .o_short_green(w_ns_short_g), .o_short_yellow(w_ns_short_y)
  );

  light_phase_checker #(
    .CNT_W(CNT_W), .MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW)
  ) u_ew_chk (
    .i_clk(clk), .i_rst(rst), .i_cur(r_cur_ew), .i_prev(r_prev_ew),
    .o_valid(w_ew_valid), .o_illegal(w_ew_illegal),
    .o_short_green(w_ew_short_g), .o_short_yellow(w_ew_short_y)
  );

  // Sample and history registers; reset to red/red so the first R->G is legal
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_ns  <= LIGHT_RED;
      r_prev_ns <= LIGHT_RED;
      r_cur_ew  <= LIGHT_RED;
      r_prev_ew <= LIGHT_RED;
    end else begin
      r_cur_ns  <= ns_light;
      r_prev_ns <= r_cur_ns;
      r_cur_ew  <= ew_light;
      r_prev_ew <= r_cur_ew;
    end
  end

  // Watchdog: cycles with no change on either bus, saturating at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog <= '0;
    end else if ((r_cur_ns != r_prev_ns) || (r_cur_ew != r_prev_ew)) begin
      r_wdog <= '0;
    end else if (r_wdog != MAX_STABLE) begin
      r_wdog <= r_wdog + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_wdog <= r_wdog;
    end
  end

  // Fault detection with fixed priority (lowest code wins)
  always_comb begin
    // Any non-red value counts, including invalid encodings
    w_conflict = (r_cur_ns != LIGHT_RED) && (r_cur_ew != LIGHT_RED);
    w_ns_r2g   = (r_prev_ns == LIGHT_RED) && (r_cur_ns == LIGHT_GREEN);
    if (w_conflict) begin
      w_code = FLT_CONFLICT;
    end else if (!w_ns_valid || !w_ew_valid) begin
      w_code = FLT_INVALID;
    end else if (w_ns_illegal || w_ew_illegal) begin
      w_code = FLT_ILLEGAL;
    end else if (w_ns_short_g || w_ew_short_g) begin
      w_code = FLT_SHORT_GREEN;
    end else if (w_ns_short_y || w_ew_short_y) begin
      w_code = FLT_SHORT_YELLOW;
    end else if (r_wdog == MAX_STABLE) begin
      w_code = FLT_WATCHDOG;
    end else begin
      w_code = FLT_NONE;
    end
  end

  // Fault latch, conflict flag and NS cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault       <= 1'b0;
      r_fault_code  <= FLT_NONE;
      r_conflict    <= 1'b0;
      r_cycle_count <= 8'd0;
    end else begin
      // A new detection overrides a simultaneous clear
      if ((w_code != FLT_NONE) && (!r_fault || clr_fault)) begin
        r_fault      <= 1'b1;
        r_fault_code <= w_code;
      end else if (clr_fault) begin
        r_fault      <= 1'b0;
        r_fault_code <= FLT_NONE;
      end else begin
        r_fault      <= r_fault;
        r_fault_code <= r_fault_code;
      end
      r_conflict <= w_conflict;
      if (w_ns_r2g) begin
        r_cycle_count <= r_cycle_count + 8'd1;
      end else begin
        r_cycle_count <= r_cycle_count;
      end
    end
  end

  assign fault       = r_fault;
  assign fault_code  = r_fault_code;
  assign conflict    = r_conflict;
  assign cycle_count = r_cycle_count;

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Safety monitor that sits on the receiving end of the traffic light controller's `ns_light`/`ew_light` outputs and checks them independently. It decodes both light buses, enforces the legal colour sequence and minimum phase times, and detects conflicting greens, invalid encodings and stuck outputs. It latches the first fault with a code until it is cleared. It also counts completed NS cycles, for system health reporting.

## Interface
Parameters:
- `CNT_W`, 16: width of dwell and watchdog counters.
- `MIN_GREEN`, 16'd1000: minimum cycles a green must be held before going yellow.
- `MIN_YELLOW`, 16'd100: minimum cycles a yellow must be held before going red.
- `MAX_STABLE`, 16'd60000: watchdog limit, in cycles, with no change on either bus.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `clr_fault`  in  1  synchronous clear of the latched fault.
- `ns_light`  in  3  observed NS light (100 = red, 010 = yellow, 001 = green).
- `ew_light`  in  3  observed EW light, same encoding.
- `fault`  out  1  sticky fault flag.
- `fault_code`  out  3  code of the first fault latched since the last clear.
- `conflict`  out  1  registered per-cycle flag: both directions non-red this sample.
- `cycle_count`  out  8  count of NS red-to-green transitions; wraps.

## Operation
- Sample stage: `cur_ns`/`cur_ew` register the inputs each cycle. Prev stage: `prev_*` hold the previous sample. All checks compare `cur` against `prev`.
- Each direction has a dwell counter:
  - Reset to 1 when `cur` ≠ `prev`.
  - Otherwise increments, saturating at all-ones.
- The watchdog counter:
  - Resets to 0 when either direction changes.
  - Otherwise increments.
  - Saturates at `MAX_STABLE`.
- Fault codes; the lowest code wins when several occur in the same cycle:
  - 0 none.
  - 1 conflict: both `cur` values non-red.
  - 2 invalid encoding: a `cur` value not in {100, 010, 001}.
  - 3 illegal transition: any change other than R→G, G→Y or Y→R.
  - 4 short green: G→Y taken with dwell < `MIN_GREEN`.
  - 5 short yellow: Y→R taken with dwell < `MIN_YELLOW`.
  - 6 watchdog: watchdog counter reaches `MAX_STABLE`.
- Codes 3, 4 and 5 are evaluated only when both `prev` and `cur` are valid encodings. Invalid values report code 2 only.
- Latching:
  - If `fault` is 0 and a code ≠ 0 is detected, set `fault` = 1 and load `fault_code`.
  - While `fault` = 1, further faults do not change `fault_code`.
  - `clr_fault` clears `fault` and `fault_code` to 0. If a fault is detected in the same cycle, it is latched instead (detect beats clear).
- `conflict` tracks code-1 detection every cycle and is not sticky.
- `cycle_count` increments by 1 on each NS R→G transition, wrapping 255→0.

## Timing
- Reset values:
  - `fault` = 0, `fault_code` = 0, `conflict` = 0, `cycle_count` = 0.
  - `cur_*` and `prev_*` = 100 (red), so the first R→G after reset is legal.
  - Dwell counters = 1; watchdog = 0.
- Latency: an input value present at edge k is in `cur` after edge k. Any resulting fault, `conflict` or `cycle_count` update is visible after edge k+1.
- Reset asserted mid-operation discards all history on the next edge. The first post-reset transition is judged against red/red.
- Watchdog: with inputs constant from reset, `fault_code` becomes 6 after edge `MAX_STABLE`+1.
- Dwell semantics: a green held for exactly `MIN_GREEN` samples and then going yellow is legal. One sample fewer raises code 4.

## Structure
- Package `traffic_light_pkg`:
  - Light encodings `LIGHT_RED`, `LIGHT_YELLOW`, `LIGHT_GREEN`.
  - Fault code constants `FLT_NONE` … `FLT_WATCHDOG`.
  - The package is shared with the controller.
- Sub-module `light_phase_checker`, instantiated once per direction. It contains:
  - the dwell counter,
  - transition legality,
  - short-green/short-yellow detection,
  - the encoding-valid flag.
- The top level holds the conflict check, watchdog, priority encoder, fault latch and `cycle_count`.

## Test plan
All scenarios use `MIN_GREEN` = 8, `MIN_YELLOW` = 4, `MAX_STABLE` = 64.
- Nominal: drive NS G10/Y5/R and EW G10/Y5/R alternately for 3 rounds → `fault` stays 0, `cycle_count` = 3.
- Conflict: set `ns_light` = 001 and `ew_light` = 001 for 1 cycle → `conflict` pulses for 1 cycle 2 edges later; `fault_code` = 1.
- Invalid plus priority: `ns_light` = 011 while `ew_light` goes G→R → `fault_code` = 2, not 3.
- Short yellow: NS G10 then Y3 then R → `fault_code` = 5. Apply `clr_fault` → 0. Then a legal sequence → `fault` stays 0.
- Watchdog: hold red/red from reset → `fault_code` = 6 exactly after edge 65. Assert `clr_fault` together with a new conflict → `fault_code` = 1.
- Reset mid-yellow: NS Y for 2 cycles, then pulse `rst`, then drive R→G → no fault; `cycle_count` = 1.
